// File: rtl/udp_payload_sched.sv
// Ping-pong bank scheduler for the UDP payload RAM: the parser fills one bank while
// the other is streamed out over valid/ready; frames arriving with no free bank are dropped.
module udp_payload_sched #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_done_i,
    input  logic [ADDR_W-1:0] frame_last_i,
    output logic              wr_bank_o,
    output logic [ADDR_W:0]   ram_rd_addr_o,
    input  logic [DATA_W-1:0] ram_rd_data_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic [DROP_W-1:0] drop_count_o,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LAT  = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [1:0]        full_q, full_d;
    logic [ADDR_W-1:0] len_q [2];
    logic [ADDR_W-1:0] len_d [2];
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              relFrame;

    // A bank released by the final handshake is free again in the same cycle,
    // so a coinciding frame_done is accepted rather than dropped.
    always_comb begin
        relFrame  = (state_q == S_HOLD) && m_ready_i && last_q;
        full_d    = full_q;
        len_d     = len_q;
        wr_bank_d = wr_bank_q;
        drop_d    = drop_q;
        if (relFrame) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (frame_done_i) begin
            if (!full_d[~wr_bank_q]) begin
                full_d[wr_bank_q] = 1'b1;
                len_d[wr_bank_q]  = frame_last_i;
                wr_bank_d         = ~wr_bank_q;
            end else if (drop_q != {DROP_W{1'b1}}) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_ptr_d  = rd_ptr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        case (state_q)
            S_IDLE: begin
                if (full_q[~wr_bank_q]) begin
                    rd_bank_d = ~wr_bank_q;
                    rd_ptr_d  = '0;
                    addr_d    = {~wr_bank_q, {ADDR_W{1'b0}}};
                    state_d   = S_LAT;
                end
            end
            S_LAT: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                data_d  = ram_rd_data_i;
                valid_d = 1'b1;
                last_d  = (rd_ptr_q == len_q[rd_bank_q]);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (m_ready_i) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        addr_d   = {rd_bank_q, rd_ptr_q + ADDR_W'(1)};
                        state_d  = S_LAT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_bank_q <= 1'b0;
            full_q    <= 2'b00;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
            rd_bank_q <= 1'b0;
            rd_ptr_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            len_q[0]  <= len_d[0];
            len_q[1]  <= len_d[1];
            rd_bank_q <= rd_bank_d;
            rd_ptr_q  <= rd_ptr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            drop_q    <= drop_d;
        end
    end

    assign wr_bank_o     = wr_bank_q;
    assign ram_rd_addr_o = addr_q;
    assign m_data_o      = data_q;
    assign m_valid_o     = valid_q;
    assign m_last_o      = last_q;
    assign drop_count_o  = drop_q;
    assign busy_o        = (state_q != S_IDLE) || (|full_q);

endmodule

// File: tb/tb_udp_payload_sched.sv
// Bench for udp_payload_sched: a frame-level model (pending frames, expected beat queue,
// write bank, drop count) is updated on the falling edge and compared against the DUT.
module tb_udp_payload_sched;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int DRW = 16;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frameDone = 1'b0;
    logic [AW-1:0] frameLast = '0;
    logic          wrBank;
    logic [AW:0]   ramRdAddr;
    logic [DW-1:0] ramRdData;
    logic [DW-1:0] mData;
    logic          mValid;
    logic          mLast;
    logic          mReady = 1'b0;
    logic [DRW-1:0] dropCount;
    logic          busy;

    logic [DW-1:0] mem [0:(1<<(AW+1))-1];

    int    total = 0;
    int    bad = 0;
    beat_t expQ[$];
    int    pending = 0;
    logic  mWrBank = 1'b0;
    int    mDrop = 0;
    beat_t monB;
    beat_t pushB;

    udp_payload_sched #(.ADDR_W(AW), .DATA_W(DW), .DROP_W(DRW)) dut (
        .clk(clk),
        .rst(rst),
        .frame_done_i(frameDone),
        .frame_last_i(frameLast),
        .wr_bank_o(wrBank),
        .ram_rd_addr_o(ramRdAddr),
        .ram_rd_data_i(ramRdData),
        .m_data_o(mData),
        .m_valid_o(mValid),
        .m_last_o(mLast),
        .m_ready_i(mReady),
        .drop_count_o(dropCount),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ramRdData <= mem[ramRdAddr];

    // Frame-level reference: at most one accepted frame may be outstanding; a frame_done
    // is accepted when none is (counting one that finishes on this very edge).
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            pending = 0;
            mWrBank = 1'b0;
            mDrop   = 0;
        end else begin
            total++;
            if (wrBank !== mWrBank) begin
                bad++;
                $display("[TB] FAIL wr_bank: got %b want %b at %0t", wrBank, mWrBank, $time);
            end
            total++;
            if (dropCount !== DRW'(mDrop)) begin
                bad++;
                $display("[TB] FAIL drop_count: got %0d want %0d at %0t", dropCount, mDrop, $time);
            end
            if (mValid === 1'b1 && mReady === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected beat: got data %h want none at %0t", mData, $time);
                end else begin
                    monB = expQ.pop_front();
                    if (mData !== monB.d || mLast !== monB.l) begin
                        bad++;
                        $display("[TB] FAIL beat: got %h/%b want %h/%b at %0t", mData, mLast, monB.d, monB.l, $time);
                    end
                    if (monB.l) pending--;
                end
            end
            if (frameDone === 1'b1) begin
                if (pending == 0) begin
                    for (int i = 0; i <= int'(frameLast); i++) begin
                        pushB.d = mem[{mWrBank, AW'(i)}];
                        pushB.l = (i == int'(frameLast));
                        expQ.push_back(pushB);
                    end
                    pending++;
                    mWrBank = ~mWrBank;
                end else if (mDrop < 65535) begin
                    mDrop++;
                end
            end
        end
    end

    task automatic fillBank(input logic bank, input int last, input logic [DW-1:0] base, input bit rnd);
        for (int i = 0; i <= last; i++) mem[{bank, AW'(i)}] = rnd ? DW'($urandom) : base + DW'(i);
    endtask

    task automatic pulseFrame(input int last, input logic [DW-1:0] base, input bit rnd);
        fillBank(mWrBank, last, base, rnd);
        frameLast = AW'(last);
        frameDone = 1'b1;
        @(posedge clk); #1;
        frameDone = 1'b0;
    endtask

    task automatic waitValid(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (mValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic waitDrain(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (expQ.size() == 0 && pending == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic doReset();
        frameDone = 1'b0;
        mReady    = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        frameDone = 1'b0;
        mReady    = 1'b0;
        #1 rst = 1'b1;
        #1;
        total++; if (mValid !== 1'b0)     begin bad++; $display("[TB] FAIL reset m_valid: got %b want 0", mValid); end
        total++; if (mLast !== 1'b0)      begin bad++; $display("[TB] FAIL reset m_last: got %b want 0", mLast); end
        total++; if (mData !== '0)        begin bad++; $display("[TB] FAIL reset m_data: got %h want 0", mData); end
        total++; if (ramRdAddr !== '0)    begin bad++; $display("[TB] FAIL reset ram_rd_addr: got %h want 0", ramRdAddr); end
        total++; if (wrBank !== 1'b0)     begin bad++; $display("[TB] FAIL reset wr_bank: got %b want 0", wrBank); end
        total++; if (dropCount !== '0)    begin bad++; $display("[TB] FAIL reset drop_count: got %0d want 0", dropCount); end
        total++; if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        doReset();
        mReady = 1'b1;
        pulseFrame(3, 32'hA0, 1'b0);
        total++; if (wrBank !== 1'b1) begin bad++; $display("[TB] FAIL single wr_bank: got %b want 1", wrBank); end
        total++; if (busy !== 1'b1)   begin bad++; $display("[TB] FAIL single busy: got %b want 1", busy); end
        @(posedge clk); #1;
        total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL single early valid E+1: got %b want 0", mValid); end
        @(posedge clk); #1;
        total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL single early valid E+2: got %b want 0", mValid); end
        @(posedge clk); #1;
        total++; if (mValid !== 1'b1 || mData !== 32'hA0 || mLast !== 1'b0) begin
            bad++; $display("[TB] FAIL single first beat E+3: got %b/%h/%b want 1/a0/0", mValid, mData, mLast);
        end
        waitDrain(60, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL single drain: got timeout want drained"); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single busy after release: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [AW:0] expAddr;
        doReset();
        mReady = 1'b1;
        pulseFrame(1, 0, 1'b1);
        waitDrain(60, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL b2b drain A: got timeout want drained"); end
        pulseFrame(2, 0, 1'b1);
        @(posedge clk); #1;
        expAddr = {1'b1, {AW{1'b0}}};
        total++; if (ramRdAddr !== expAddr) begin bad++; $display("[TB] FAIL b2b addr B: got %h want %h", ramRdAddr, expAddr); end
        waitDrain(60, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL b2b drain B: got timeout want drained"); end
        total++; if (dropCount !== '0) begin bad++; $display("[TB] FAIL b2b drop: got %0d want 0", dropCount); end
        total++; if (wrBank !== 1'b0) begin bad++; $display("[TB] FAIL b2b wr_bank: got %b want 0", wrBank); end
    endtask

    task automatic test_drop();
        bit ok;
        doReset();
        pulseFrame(2, 32'hB0, 1'b0);
        waitValid(20, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL drop wait valid: got timeout want valid"); end
        pulseFrame(4, 32'hC0, 1'b0);
        total++; if (dropCount !== DRW'(1)) begin bad++; $display("[TB] FAIL drop count: got %0d want 1", dropCount); end
        total++; if (wrBank !== 1'b1) begin bad++; $display("[TB] FAIL drop wr_bank: got %b want 1", wrBank); end
        total++; if (mData !== 32'hB0) begin bad++; $display("[TB] FAIL drop held data: got %h want b0", mData); end
        mReady = 1'b1;
        waitDrain(60, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL drop drain: got timeout want drained"); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL drop busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [AW:0] expAddr;
        doReset();
        pulseFrame(3, 0, 1'b1);
        waitValid(20, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL bp wait valid: got timeout want valid"); end
        expAddr = '0;
        for (int c = 0; c < 10; c++) begin
            total++;
            if (mValid !== 1'b1 || mLast !== 1'b0 || mData !== mem[0] || ramRdAddr !== expAddr) begin
                bad++;
                $display("[TB] FAIL bp hold cycle %0d: got %b/%b/%h/%h want 1/0/%h/%h", c, mValid, mLast, mData, ramRdAddr, mem[0], expAddr);
            end
            @(posedge clk); #1;
        end
        mReady = 1'b1;
        @(posedge clk); #1;
        mReady = 1'b0;
        expAddr = {1'b0, AW'(1)};
        total++; if (mValid !== 1'b0 || ramRdAddr !== expAddr) begin
            bad++; $display("[TB] FAIL bp after beat: got %b/%h want 0/%h", mValid, ramRdAddr, expAddr);
        end
        waitValid(20, ok);
        total++; if (!ok || mData !== mem[1]) begin bad++; $display("[TB] FAIL bp second word: got %h want %h", mData, mem[1]); end
        mReady = 1'b1;
        waitDrain(60, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL bp drain: got timeout want drained"); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [AW:0] expAddr;
        doReset();
        pulseFrame(0, 32'hD0, 1'b0);
        waitValid(20, ok);
        total++; if (!ok || mLast !== 1'b1) begin bad++; $display("[TB] FAIL simul single-beat last: got %b want 1", mLast); end
        mReady = 1'b1;
        pulseFrame(2, 32'hE0, 1'b0);
        total++; if (dropCount !== '0) begin bad++; $display("[TB] FAIL simul drop: got %0d want 0", dropCount); end
        total++; if (wrBank !== 1'b0) begin bad++; $display("[TB] FAIL simul wr_bank: got %b want 0", wrBank); end
        total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL simul valid after release: got %b want 0", mValid); end
        @(posedge clk); #1;
        expAddr = {1'b1, {AW{1'b0}}};
        total++; if (ramRdAddr !== expAddr) begin bad++; $display("[TB] FAIL simul restart addr: got %h want %h", ramRdAddr, expAddr); end
        waitDrain(60, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL simul drain: got timeout want drained"); end
    endtask

    task automatic test_async_reset();
        bit ok;
        doReset();
        pulseFrame(3, 0, 1'b1);
        waitValid(20, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL areset wait valid: got timeout want valid"); end
        pulseFrame(1, 0, 1'b1);
        #2 rst = 1'b1;
        #1;
        total++; if (mValid !== 1'b0 || mLast !== 1'b0 || mData !== '0) begin
            bad++; $display("[TB] FAIL areset stream outs: got %b/%b/%h want 0/0/0", mValid, mLast, mData);
        end
        total++; if (ramRdAddr !== '0 || wrBank !== 1'b0) begin
            bad++; $display("[TB] FAIL areset addr/bank: got %h/%b want 0/0", ramRdAddr, wrBank);
        end
        total++; if (dropCount !== '0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL areset drop/busy: got %0d/%b want 0/0", dropCount, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mReady = 1'b1;
        pulseFrame(2, 32'hF0, 1'b0);
        waitValid(20, ok);
        total++; if (!ok || mData !== 32'hF0) begin bad++; $display("[TB] FAIL areset restart word: got %h want f0", mData); end
        waitDrain(60, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL areset drain: got timeout want drained"); end
    endtask

    task automatic test_full_bank();
        bit ok;
        doReset();
        mReady = 1'b1;
        pulseFrame((1 << AW) - 1, 0, 1'b1);
        waitDrain(4000, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL full bank drain: got timeout want drained"); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL full bank busy: got %b want 0", busy); end
    endtask

    task automatic test_random();
        bit ok;
        int last;
        doReset();
        for (int c = 0; c < 800; c++) begin
            mReady = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 5) == 0) begin
                last = $urandom_range(0, 6);
                fillBank(mWrBank, last, 0, 1'b1);
                frameLast = AW'(last);
                frameDone = 1'b1;
            end else begin
                frameDone = 1'b0;
            end
            @(posedge clk); #1;
        end
        frameDone = 1'b0;
        mReady = 1'b1;
        waitDrain(200, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL random drain: got timeout want drained"); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL random busy: got %b want 0", busy); end
    endtask

    initial begin
        for (int i = 0; i < (1 << (AW + 1)); i++) mem[i] = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_backpressure();
        test_simultaneous();
        test_async_reset();
        test_full_bank();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
